conv_operand_streamer: RTL and testbench

- Producer side of the a/b operand handshake consumed by the convolution controller.
- Walks the same six-deep loop nest as the consumer (x, y, ch_in, ch_out, ky, kx; kx innermost).
- Fetches activations and kernel weights from two external single-port read memories (1-cycle read latency), inserts zeros for padding, and presents one (a, b) pair per transfer.
- Sits between the host-loaded operand memories and the accelerator's a/b inputs.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/operand_skid_fifo.sv | 47 ++++
 rtl/conv_operand_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_conv_operand_streamer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the convolution operand streamer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } streamer_state_t;

    localparam int DEFAULT_KERNEL_SIZE = 3;
    localparam int PAD                 = DEFAULT_KERNEL_SIZE / 2;

    // Padding on each side for an odd kernel edge.
    function automatic int pad_of(input int kernel_size);
        return kernel_size / 2;
    endfunction

    // Bits needed to hold a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of (a, b) pairs produced by one full pass of the loop nest.
    function automatic longint total_pairs(input int w, input int h, input int cin,
                                           input int cout, input int k);
        return longint'(w) * longint'(h) * longint'(cin) * longint'(cout) *
               longint'(k) * longint'(k);
    endfunction

endpackage

// File: rtl/operand_skid_fifo.sv
// Two-entry FIFO holding captured operand pairs; the head feeds the consumer.
module operand_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/conv_operand_streamer.sv
// Producer of (activation, weight) operand pairs for the convolution controller.
// Walks x, y, ch_in, ch_out, ky, kx (kx innermost), fetches both operands from
// 1-cycle-latency memories, zero-fills padding, and hands pairs out through a
// 2-entry FIFO under a credit rule that can never overflow it.
module conv_operand_streamer
    import conv_pkg::*;
#(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int DATA_WIDTH         = 16
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          act_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] act_addr,
    input  logic [DATA_WIDTH-1:0]         act_rdata,
    output logic                          ker_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] ker_addr,
    input  logic [DATA_WIDTH-1:0]         ker_rdata,
    output logic [DATA_WIDTH-1:0]         a_data,
    output logic                          a_valid,
    input  logic                          a_ready,
    output logic [DATA_WIDTH-1:0]         b_data,
    output logic                          b_valid,
    input  logic                          b_ready
);

    localparam int PAD_L = pad_of(KERNEL_SIZE);
    localparam int XW    = cnt_width(FEATURE_MAP_WIDTH);
    localparam int YW    = cnt_width(FEATURE_MAP_HEIGHT);
    localparam int CIW   = cnt_width(INPUT_NB_CHANNELS);
    localparam int COW   = cnt_width(OUTPUT_NB_CHANNELS);
    localparam int KW    = cnt_width(KERNEL_SIZE);

    localparam logic [XW-1:0]  X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [CIW-1:0] CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
    localparam logic [COW-1:0] CO_MAX = COW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);

    streamer_state_t state;

    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [CIW-1:0] ch_in;
    logic [COW-1:0] ch_out;
    logic [KW-1:0]  ky;
    logic [KW-1:0]  kx;

    logic kx_wrap, ky_wrap, co_wrap, ci_wrap, y_wrap, x_wrap;
    logic ky_step, co_step, ci_step, y_step, x_step;
    logic last_pos;

    int   xi, yi, act_lin, ker_lin;
    logic pad;

    logic                      inflight;
    logic                      pad_q;
    logic [2*DATA_WIDTH-1:0]   push_data;
    logic [2*DATA_WIDTH-1:0]   head;
    logic [1:0]                fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic [2:0]                occupancy;
    logic                      issue;
    logic                      drain_done;

    // Carry chain: each counter steps when every inner counter wraps.
    assign kx_wrap  = (kx == K_MAX);
    assign ky_step  = kx_wrap;
    assign ky_wrap  = ky_step && (ky == K_MAX);
    assign co_step  = ky_wrap;
    assign co_wrap  = co_step && (ch_out == CO_MAX);
    assign ci_step  = co_wrap;
    assign ci_wrap  = ci_step && (ch_in == CI_MAX);
    assign y_step   = ci_wrap;
    assign y_wrap   = y_step && (y == Y_MAX);
    assign x_step   = y_wrap;
    assign x_wrap   = x_step && (x == X_MAX);
    assign last_pos = x_wrap;

    // Input coordinate, padding decision and both memory addresses for the current position.
    always_comb begin
        xi      = int'(x) + int'(kx) - PAD_L;
        yi      = int'(y) + int'(ky) - PAD_L;
        pad     = (xi < 0) || (xi >= FEATURE_MAP_WIDTH) ||
                  (yi < 0) || (yi >= FEATURE_MAP_HEIGHT);
        act_lin = (yi * FEATURE_MAP_WIDTH + xi) * INPUT_NB_CHANNELS + int'(ch_in);
        ker_lin = ((int'(ch_out) * INPUT_NB_CHANNELS + int'(ch_in)) * KERNEL_SIZE +
                   int'(ky)) * KERNEL_SIZE + int'(kx);
    end

    assign pop     = a_valid && a_ready && b_ready;
    // Slots already promised: stored pairs plus the read in flight, minus the one leaving.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    // A full FIFO without a pop can never take another pair; the occupancy test covers it too.
    assign issue   = (state == STREAM) && (occupancy < 3'd2) && !(fifo_full && !pop);

    assign act_re   = issue && !pad;
    assign ker_re   = issue;
    assign act_addr = LOG2_OF_MEM_HEIGHT'(act_lin);
    assign ker_addr = LOG2_OF_MEM_HEIGHT'(ker_lin);

    // Nothing left anywhere once this cycle's pop (if any) completes.
    assign drain_done = (state == DRAIN) && !inflight &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    // Control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (issue && last_pos) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Loop-nest counters advance once per issued fetch; a full pass returns them to zero.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            x      <= '0;
            y      <= '0;
            ch_in  <= '0;
            ch_out <= '0;
            ky     <= '0;
            kx     <= '0;
        end else if (issue) begin
            kx <= kx_wrap ? '0 : kx + KW'(1);
            if (ky_step) ky     <= ky_wrap ? '0 : ky + KW'(1);
            if (co_step) ch_out <= co_wrap ? '0 : ch_out + COW'(1);
            if (ci_step) ch_in  <= ci_wrap ? '0 : ch_in + CIW'(1);
            if (y_step)  y      <= y_wrap  ? '0 : y + YW'(1);
            if (x_step)  x      <= x_wrap  ? '0 : x + XW'(1);
        end
    end

    // Read-in-flight marker; dropped on reset so a pending read never lands.
    always_ff @(posedge clk) begin
        if (!arst_n_in) inflight <= 1'b0;
        else            inflight <= issue;
    end

    // Pad flag travels with its read so the activation can be zeroed at capture.
    always_ff @(posedge clk) begin
        pad_q <= pad;
    end

    assign push_data = {pad_q ? {DATA_WIDTH{1'b0}} : act_rdata, ker_rdata};

    operand_skid_fifo #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (arst_n_in),
        .push     (inflight),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign a_valid = !fifo_empty;
    assign b_valid = !fifo_empty;
    assign a_data  = a_valid ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign b_data  = b_valid ? head[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_conv_operand_streamer.sv
// Directed bench for conv_operand_streamer on a 4x4x2x2 map with a 3x3 kernel.
module tb_conv_operand_streamer;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int CIN   = 2;
    localparam int COUT  = 2;
    localparam int K     = 3;
    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int TOTAL = 576;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic          busy, done;
    logic          act_re, ker_re;
    logic [AW-1:0] act_addr, ker_addr;
    logic [DW-1:0] act_rdata = '0;
    logic [DW-1:0] ker_rdata = '0;
    logic [DW-1:0] a_data, b_data;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int fetch_cnt = 0;
    int done_cnt = 0;
    int last_pop_cyc = 0;
    bit mon_en = 1'b0;
    bit chk_special = 1'b0;
    bit hold_prev = 1'b0;
    logic [31:0] held;
    logic [31:0] exp_q[$];

    conv_operand_streamer #(
        .LOG2_OF_MEM_HEIGHT(AW),
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS (CIN),
        .OUTPUT_NB_CHANNELS(COUT),
        .KERNEL_SIZE       (K),
        .DATA_WIDTH        (DW)
    ) dut (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .act_re   (act_re),
        .act_addr (act_addr),
        .act_rdata(act_rdata),
        .ker_re   (ker_re),
        .ker_addr (ker_addr),
        .ker_rdata(ker_rdata),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: activation mem[i] = i, kernel mem[i] = 1000 + i, 1-cycle read.
    always @(posedge clk) begin
        if (act_re) act_rdata <= act_addr[DW-1:0];
        if (ker_re) ker_rdata <= 16'(1000 + int'(ker_addr));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Independent model of the loop nest: every pair in pop order.
    task automatic fill_expected();
        int xi, yi, a, kaddr;
        exp_q.delete();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                for (int ci = 0; ci < CIN; ci++)
                    for (int co = 0; co < COUT; co++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++) begin
                                xi    = x + kx - K / 2;
                                yi    = y + ky - K / 2;
                                kaddr = ((co * CIN + ci) * K + ky) * K + kx;
                                if (xi < 0 || xi >= W || yi < 0 || yi >= H) a = 0;
                                else a = (yi * W + xi) * CIN + ci;
                                exp_q.push_back({16'(a), 16'(1000 + kaddr)});
                            end
    endtask

    // Scoreboard: compare every popped pair, and hold-stability under backpressure.
    always @(negedge clk) begin
        logic        pop;
        logic [31:0] e;
        if (ker_re) fetch_cnt++;
        if (done) done_cnt++;
        if (mon_en) begin
            chk("valid_equal", 64'(a_valid), 64'(b_valid));
            if (hold_prev) begin
                chk("hold_valid", 64'(a_valid), 64'd1);
                chk("hold_data", 64'({a_data, b_data}), 64'(held));
            end
            pop = a_valid && a_ready && b_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pop", 64'(pop_cnt), 64'(TOTAL));
                end else begin
                    e = exp_q.pop_front();
                    chk("pair", 64'({a_data, b_data}), 64'(e));
                    if (chk_special && pop_cnt == 4)
                        chk("pair4_centre", 64'({a_data, b_data}), 64'({16'd0, 16'd1004}));
                    if (chk_special && pop_cnt == 202)
                        chk("pair_x1y1_ci1", 64'({a_data, b_data}), 64'({16'd11, 16'd1013}));
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            hold_prev = a_valid && !pop;
            held      = {a_data, b_data};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (rnd) begin
                a_ready = 1'($urandom_range(0, 1));
                b_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic finish_run(input string tag, input bit ok);
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
        chk({tag, "_pop_count"}, 64'(pop_cnt), 64'(TOTAL));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_done_after_last_pop"}, 64'(cyc), 64'(last_pop_cyc + 1));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit ok;
        arst_n_in = 1'b0;
        start     = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'({a_valid, b_valid}), 64'd0);
        chk("rst_re", 64'({act_re, ker_re}), 64'd0);
        chk("rst_data", 64'({a_data, b_data}), 64'd0);
        arst_n_in = 1'b1;

        // Run A: no backpressure, latency and throughput.
        a_ready = 1'b1; b_ready = 1'b1;
        fill_expected();
        pop_cnt = 0; mon_en = 1'b1; chk_special = 1'b1;
        pulse_start();
        chk("A_busy_after_start", 64'(busy), 64'd1);
        chk("A_first_ker_re", 64'(ker_re), 64'd1);
        chk("A_first_act_re_pad", 64'(act_re), 64'd0);
        chk("A_first_ker_addr", 64'(ker_addr), 64'd0);
        chk("A_no_valid_c0", 64'(a_valid), 64'd0);
        @(posedge clk); #1;
        chk("A_no_valid_c1", 64'(a_valid), 64'd0);
        @(posedge clk); #1;
        chk("A_valid_c2", 64'(a_valid), 64'd1);
        chk("A_first_pair", 64'({a_data, b_data}), 64'({16'd0, 16'd1000}));
        wait_done(2000, 1'b0, ok);
        finish_run("A", ok);
        chk_special = 1'b0;

        // Run B: random backpressure on both readies.
        fill_expected();
        pop_cnt = 0;
        pulse_start();
        wait_done(6000, 1'b1, ok);
        a_ready = 1'b1; b_ready = 1'b1;
        finish_run("B", ok);

        // Run C: a ready, b not ready for ten cycles.
        fill_expected();
        pop_cnt = 0;
        a_ready = 1'b1; b_ready = 1'b0;
        fetch_cnt = 0;
        pulse_start();
        repeat (10) begin @(posedge clk); #1; end
        chk("C_no_pop", 64'(pop_cnt), 64'd0);
        chk("C_valid_held", 64'(a_valid), 64'd1);
        chk("C_data_held", 64'({a_data, b_data}), 64'(exp_q[0]));
        chk("C_fetch_bound", 64'(fetch_cnt <= 2), 64'd1);
        b_ready = 1'b1;
        wait_done(2000, 1'b0, ok);
        finish_run("C", ok);

        // Run D: reset at pair 100, then a clean restart.
        fill_expected();
        pop_cnt = 0;
        pulse_start();
        for (int i = 0; i < 300 && pop_cnt < 100; i++) begin @(posedge clk); #1; end
        chk("D_reached_100", 64'(pop_cnt), 64'd100);
        mon_en = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        arst_n_in = 1'b0;
        @(posedge clk); #1;
        chk("D_rst_busy", 64'(busy), 64'd0);
        chk("D_rst_valid", 64'(a_valid), 64'd0);
        chk("D_rst_done", 64'(done), 64'd0);
        chk("D_rst_act_re", 64'(act_re), 64'd0);
        arst_n_in = 1'b1;
        fill_expected();
        pop_cnt = 0; mon_en = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        pulse_start();
        chk("D_restart_ker_addr", 64'(ker_addr), 64'd0);
        chk("D_restart_act_re", 64'(act_re), 64'd0);
        wait_done(2000, 1'b0, ok);
        finish_run("D", ok);

        // Run E: start pulsed again while busy is ignored.
        fill_expected();
        pop_cnt = 0; done_cnt = 0;
        pulse_start();
        repeat (20) begin @(posedge clk); #1; end
        chk("E_busy_mid", 64'(busy), 64'd1);
        pulse_start();
        wait_done(2000, 1'b0, ok);
        finish_run("E", ok);
        repeat (5) begin @(posedge clk); #1; end
        chk("E_single_done", 64'(done_cnt), 64'd1);
        chk("E_no_restart", 64'({busy, a_valid}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
